// File: rtl/snes_dejitter_ctrl.sv
// Line-timing and lock controller for the SNES dejitter GCLK gate.
// Optional statistics counters are enabled by defining DEJITTER_STATS_EN.
module snes_dejitter_ctrl #(
   parameter int NOM_LEN    = 1364,
   parameter int SHORT_LEN  = 1360,
   parameter int MIN_LEN    = 1024,
   parameter int GATE_CYC   = 4,
   parameter int LOCK_LINES = 8,
   parameter int ERR_MAX    = 3
) (
   input  logic        CLK_i,
   input  logic        RST_i,
   input  logic        CSYNC_i,
   input  logic        EN_i,
   output logic        GCLK_EN_o,
   output logic        CSYNC_o,
   output logic        LOCKED_o,
   output logic [10:0] LINE_LEN_o,
   output logic        SHORT_LINE_o
`ifdef DEJITTER_STATS_EN
   ,
   output logic [15:0] SHORT_CNT_o,
   output logic [7:0]  UNLOCK_CNT_o
`endif
);

   localparam logic [1:0] ST_UNLOCK = 2'd0;
   localparam logic [1:0] ST_ACQ    = 2'd1;
   localparam logic [1:0] ST_LOCK   = 2'd2;

   logic [10:0] h_cnt_q, h_cnt_d;
   logic        csync_prev_q;
   logic [2:0]  gate_cnt_q, gate_cnt_d;
   logic [1:0]  state_q, state_d;
   logic [3:0]  good_cnt_q, good_cnt_d;
   logic [2:0]  err_cnt_q, err_cnt_d;
   logic        gclk_en_q;
   logic        csync_q, csync_d;
   logic        locked_q;
   logic [10:0] line_len_q, line_len_d;
   logic        short_q;

   logic [11:0] line_len_w;
   logic        edge_w, is_nom_w, is_short_w, is_good_w, timeout_w, trigger_w;

   assign line_len_w = {1'b0, h_cnt_q} + 12'd1;
   // Falling edges before MIN_LEN are equalization/serration pulses, not line starts.
   assign edge_w     = csync_prev_q & ~CSYNC_i & (h_cnt_q >= 11'(MIN_LEN));
   assign is_nom_w   = (line_len_w == 12'(NOM_LEN));
   assign is_short_w = (line_len_w == 12'(SHORT_LEN));
   assign is_good_w  = is_nom_w | is_short_w;
   assign timeout_w  = ~edge_w & (h_cnt_q == 11'd2046);
   assign trigger_w  = edge_w & is_short_w & (state_q == ST_LOCK) & EN_i;

   always_comb begin
      state_d    = state_q;
      good_cnt_d = good_cnt_q;
      err_cnt_d  = err_cnt_q;
      case (state_q)
         ST_UNLOCK: begin
            if (edge_w) begin
               state_d    = ST_ACQ;
               good_cnt_d = 4'd0;
            end
         end
         ST_ACQ: begin
            if (edge_w) begin
               if (is_good_w) begin
                  good_cnt_d = good_cnt_q + 4'd1;
                  if (good_cnt_q + 4'd1 == 4'(LOCK_LINES)) begin
                     state_d   = ST_LOCK;
                     err_cnt_d = 3'd0;
                  end
               end else begin
                  state_d = ST_UNLOCK;
               end
            end else if (timeout_w) begin
               state_d = ST_UNLOCK;
            end
         end
         ST_LOCK: begin
            if (edge_w) begin
               if (is_good_w) begin
                  err_cnt_d = 3'd0;
               end else begin
                  err_cnt_d = err_cnt_q + 3'd1;
                  if (err_cnt_q + 3'd1 == 3'(ERR_MAX)) state_d = ST_UNLOCK;
               end
            end else if (timeout_w) begin
               state_d = ST_UNLOCK;
            end
         end
         default: state_d = ST_UNLOCK;
      endcase
   end

   always_comb begin
      h_cnt_d = h_cnt_q;
      if (edge_w) h_cnt_d = 11'd0;
      else if (h_cnt_q != 11'd2047) h_cnt_d = h_cnt_q + 11'd1;

      gate_cnt_d = gate_cnt_q;
      if (trigger_w) gate_cnt_d = 3'(GATE_CYC);
      else if (gate_cnt_q != 3'd0) gate_cnt_d = gate_cnt_q - 3'd1;

      // Regenerated sync freezes while the window runs, delaying its falling edge.
      csync_d = csync_q;
      if (!trigger_w && gate_cnt_q <= 3'd1) csync_d = CSYNC_i;

      line_len_d = edge_w ? line_len_w[10:0] : line_len_q;
   end

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         h_cnt_q      <= 11'd0;
         csync_prev_q <= 1'b1;
         gate_cnt_q   <= 3'd0;
         state_q      <= ST_UNLOCK;
         good_cnt_q   <= 4'd0;
         err_cnt_q    <= 3'd0;
         gclk_en_q    <= 1'b1;
         csync_q      <= 1'b1;
         locked_q     <= 1'b0;
         line_len_q   <= 11'd0;
         short_q      <= 1'b0;
      end else begin
         h_cnt_q      <= h_cnt_d;
         csync_prev_q <= CSYNC_i;
         gate_cnt_q   <= gate_cnt_d;
         state_q      <= state_d;
         good_cnt_q   <= good_cnt_d;
         err_cnt_q    <= err_cnt_d;
         gclk_en_q    <= (gate_cnt_d == 3'd0);
         csync_q      <= csync_d;
         locked_q     <= (state_d == ST_LOCK);
         line_len_q   <= line_len_d;
         short_q      <= edge_w & is_short_w;
      end
   end

   assign GCLK_EN_o    = gclk_en_q;
   assign CSYNC_o      = csync_q;
   assign LOCKED_o     = locked_q;
   assign LINE_LEN_o   = line_len_q;
   assign SHORT_LINE_o = short_q;

`ifdef DEJITTER_STATS_EN
   logic [15:0] short_cnt_q;
   logic [7:0]  unlock_cnt_q;

   always_ff @(posedge CLK_i) begin
      if (RST_i) begin
         short_cnt_q  <= 16'd0;
         unlock_cnt_q <= 8'd0;
      end else begin
         if (trigger_w && short_cnt_q != 16'hFFFF) short_cnt_q <= short_cnt_q + 16'd1;
         if (state_q == ST_LOCK && state_d == ST_UNLOCK && unlock_cnt_q != 8'hFF)
            unlock_cnt_q <= unlock_cnt_q + 8'd1;
      end
   end

   assign SHORT_CNT_o  = short_cnt_q;
   assign UNLOCK_CNT_o = unlock_cnt_q;
`endif

endmodule

// File: tb/tb_snes_dejitter_ctrl.sv
// Self-checking bench for snes_dejitter_ctrl with a line-level reference model.
module tb_snes_dejitter_ctrl;

   localparam int NOM_LEN    = 1364;
   localparam int SHORT_LEN  = 1360;
   localparam int MIN_LEN    = 1024;
   localparam int GATE_CYC   = 4;
   localparam int LOCK_LINES = 8;
   localparam int ERR_MAX    = 3;

   localparam int M_UNLOCK = 0;
   localparam int M_ACQ    = 1;
   localparam int M_LOCK   = 2;

   logic        CLK_i = 1'b0;
   logic        RST_i = 1'b1;
   logic        CSYNC_i = 1'b1;
   logic        EN_i = 1'b0;
   logic        GCLK_EN_o, CSYNC_o, LOCKED_o, SHORT_LINE_o;
   logic [10:0] LINE_LEN_o;
`ifdef DEJITTER_STATS_EN
   logic [15:0] SHORT_CNT_o;
   logic [7:0]  UNLOCK_CNT_o;
`endif

   snes_dejitter_ctrl dut (
      .CLK_i        (CLK_i),
      .RST_i        (RST_i),
      .CSYNC_i      (CSYNC_i),
      .EN_i         (EN_i),
      .GCLK_EN_o    (GCLK_EN_o),
      .CSYNC_o      (CSYNC_o),
      .LOCKED_o     (LOCKED_o),
      .LINE_LEN_o   (LINE_LEN_o),
      .SHORT_LINE_o (SHORT_LINE_o)
`ifdef DEJITTER_STATS_EN
      ,
      .SHORT_CNT_o  (SHORT_CNT_o),
      .UNLOCK_CNT_o (UNLOCK_CNT_o)
`endif
   );

   always #5 CLK_i = ~CLK_i;

   int checks = 0;
   int failures = 0;

   // Reference model: cycles since last line start, lock bookkeeping, gate window start.
   int          tcount = 0;
   int          since, gs, m_state, good, err, n_win, n_unl;
   logic        m_prev, exp_cso, held, m_short;
   logic [10:0] exp_len;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      since = 0; gs = -1000; m_state = M_UNLOCK; good = 0; err = 0;
      n_win = 0; n_unl = 0; m_prev = 1'b1; exp_cso = 1'b1; held = 1'b1;
      m_short = 1'b0; exp_len = 11'd0;
   endtask

   task automatic tick(input logic cs);
      int sb, len;
      bit edg, shrt, good_l;
      logic exp_gclk;
      CSYNC_i = cs;
      @(posedge CLK_i);
      #1;
      tcount++;
      if (RST_i) begin
         model_reset();
      end else begin
         sb = since;
         edg = m_prev && !cs && (sb >= MIN_LEN);
         m_short = 1'b0;
         if (edg) begin
            len = ((sb > 2047) ? 2047 : sb) + 1;
            exp_len = len[10:0];
            shrt = (len == SHORT_LEN);
            good_l = shrt || (len == NOM_LEN);
            m_short = shrt;
            if (shrt && m_state == M_LOCK && EN_i) begin
               gs = tcount; held = exp_cso; n_win++;
            end
            case (m_state)
               M_UNLOCK: begin m_state = M_ACQ; good = 0; end
               M_ACQ: begin
                  if (good_l) begin
                     good++;
                     if (good == LOCK_LINES) begin m_state = M_LOCK; err = 0; end
                  end else m_state = M_UNLOCK;
               end
               default: begin
                  if (good_l) err = 0;
                  else begin
                     err++;
                     if (err == ERR_MAX) begin m_state = M_UNLOCK; n_unl++; end
                  end
               end
            endcase
            since = 0;
         end else begin
            since = sb + 1;
            if (sb == 2046 && m_state != M_UNLOCK) begin
               if (m_state == M_LOCK) n_unl++;
               m_state = M_UNLOCK;
            end
         end
         exp_cso = (tcount >= gs && tcount < gs + GATE_CYC) ? held : cs;
         m_prev = cs;
      end
      exp_gclk = !(tcount >= gs && tcount < gs + GATE_CYC);
      check("gclk_en", {15'd0, GCLK_EN_o}, {15'd0, exp_gclk});
      check("csync_o", {15'd0, CSYNC_o}, {15'd0, exp_cso});
      check("locked", {15'd0, LOCKED_o}, {15'd0, (m_state == M_LOCK)});
      check("short_line", {15'd0, SHORT_LINE_o}, {15'd0, m_short});
      check("line_len", {5'd0, LINE_LEN_o}, {5'd0, exp_len});
`ifdef DEJITTER_STATS_EN
      check("short_cnt", SHORT_CNT_o, 16'(n_win));
      check("unlock_cnt", {8'd0, UNLOCK_CNT_o}, 16'(n_unl));
`endif
   endtask

   // One line: falling edge on the first tick, low for low_w ticks, optional serrations.
   task automatic drive_line(input int len, input int low_w, input bit serr,
                             output int gl, output int cf, output int sp);
      logic cs;
      gl = 0; cf = 0; sp = 0;
      for (int k = 1; k <= len; k++) begin
         cs = (k <= low_w) ? 1'b0 : 1'b1;
         if (serr && ((k >= 602 && k < 612) || (k >= 902 && k < 912))) cs = 1'b0;
         tick(cs);
         if (GCLK_EN_o === 1'b0) gl++;
         if (cf == 0 && CSYNC_o === 1'b0) cf = k;
         if (SHORT_LINE_o === 1'b1) sp++;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b1);
   endtask

   initial begin
      int gl, cf, sp, len, r;
      bit serr;
      model_reset();
      RST_i = 1'b1; EN_i = 1'b1;
      tick(1'b1); tick(1'b1); tick(1'b1);
      check("rst_gclk", {15'd0, GCLK_EN_o}, 16'd1);
      check("rst_csync", {15'd0, CSYNC_o}, 16'd1);
      check("rst_locked", {15'd0, LOCKED_o}, 16'd0);
      check("rst_len", {5'd0, LINE_LEN_o}, 16'd0);
      check("rst_short", {15'd0, SHORT_LINE_o}, 16'd0);
      RST_i = 1'b0;

      idle(1100);
      for (int i = 0; i < 10; i++) drive_line(NOM_LEN, 80, 1'b0, gl, cf, sp);
      check("acq_locked", {15'd0, LOCKED_o}, 16'd1);
      check("acq_len", {5'd0, LINE_LEN_o}, 16'd1364);

      drive_line(SHORT_LEN, 80, 1'b0, gl, cf, sp);
      drive_line(NOM_LEN, 80, 1'b0, gl, cf, sp);
      check("gate_low_cycles", 16'(gl), 16'(GATE_CYC));
      check("gate_csync_fall", 16'(cf), 16'(GATE_CYC + 1));
      check("gate_short_pulse", 16'(sp), 16'd1);
      check("gate_len", {5'd0, LINE_LEN_o}, 16'd1360);

      drive_line(SHORT_LEN, 80, 1'b0, gl, cf, sp);
      EN_i = 1'b0;
      drive_line(NOM_LEN, 80, 1'b0, gl, cf, sp);
      check("noen_low_cycles", 16'(gl), 16'd0);
      check("noen_csync_fall", 16'(cf), 16'd1);
      check("noen_short_pulse", 16'(sp), 16'd1);
      EN_i = 1'b1;

      drive_line(NOM_LEN, 80, 1'b1, gl, cf, sp);
      drive_line(NOM_LEN, 80, 1'b0, gl, cf, sp);
      check("serr_len", {5'd0, LINE_LEN_o}, 16'd1364);
      check("serr_locked", {15'd0, LOCKED_o}, 16'd1);

      drive_line(SHORT_LEN, 80, 1'b0, gl, cf, sp);
      tick(1'b0);
      tick(1'b0);
      check("win_gclk_low", {15'd0, GCLK_EN_o}, 16'd0);
      RST_i = 1'b1;
      tick(1'b0);
      check("midrst_gclk", {15'd0, GCLK_EN_o}, 16'd1);
      check("midrst_locked", {15'd0, LOCKED_o}, 16'd0);
`ifdef DEJITTER_STATS_EN
      check("midrst_short_cnt", SHORT_CNT_o, 16'd0);
`endif
      RST_i = 1'b0;

      idle(1100);
      for (int i = 0; i < 10; i++) drive_line(NOM_LEN, 80, 1'b0, gl, cf, sp);
      check("relock1", {15'd0, LOCKED_o}, 16'd1);
      for (int i = 0; i < 3; i++) drive_line(1200, 80, 1'b0, gl, cf, sp);
      check("bad2_locked", {15'd0, LOCKED_o}, 16'd1);
      drive_line(NOM_LEN, 80, 1'b0, gl, cf, sp);
      check("bad3_unlocked", {15'd0, LOCKED_o}, 16'd0);

      for (int i = 0; i < 11; i++) drive_line(NOM_LEN, 80, 1'b0, gl, cf, sp);
      check("relock2", {15'd0, LOCKED_o}, 16'd1);
      idle(2100);
      check("timeout_unlocked", {15'd0, LOCKED_o}, 16'd0);

      for (int i = 0; i < 14; i++) begin
         r = $urandom_range(0, 9);
         serr = 1'b0;
         if (r <= 4) len = NOM_LEN;
         else if (r <= 6) len = SHORT_LEN;
         else if (r == 7) len = 1200;
         else if (r == 8) len = $urandom_range(1025, 1500);
         else begin len = NOM_LEN; serr = 1'b1; end
         EN_i = ($urandom_range(0, 3) != 0);
         drive_line(len, $urandom_range(10, 120), serr, gl, cf, sp);
      end
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
